// File: rtl/mips_pkg.sv
// Shared MIPS control-bundle definitions for the decode/execute boundary.
// Bit positions, ALUOp encodings and the hard-wired zero register index.
package mips_pkg;

    localparam int CTRL_W = 14;

    localparam int CTRL_REGDST   = 13;
    localparam int CTRL_JUMP     = 12;
    localparam int CTRL_BRANCH   = 11;
    localparam int CTRL_MEMREAD  = 10;
    localparam int CTRL_MEMTOREG = 9;
    localparam int CTRL_ALUOP_HI = 8;
    localparam int CTRL_ALUOP_LO = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_JR       = 3;
    localparam int CTRL_REG1     = 2;
    localparam int CTRL_JAL      = 1;
    localparam int CTRL_BNE      = 0;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam int REG_ZERO = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    function automatic logic is_load(input ctrl_t c);
        return c[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use dependency check between the load in EX and the reader in ID.
// Purely combinational so the forwarding unit can share it.
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    output logic             hazard_o
);

    logic rt_live;
    logic rs_hit;
    logic rt_hit;

    // $0 is never really written, so a load to it cannot create a dependency
    assign rt_live  = (ex_rt_i != REG_W'(REG_ZERO));
    assign rs_hit   = id_use_rs_i & (ex_rt_i == id_rs_i);
    assign rt_hit   = id_use_rt_i & (ex_rt_i == id_rt_i);
    assign hazard_o = ex_mem_read_i & rt_live & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall, bubble insertion
// and a saturating bubble counter.
module id_ex_hazard_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    output logic              stall,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rt_data_q;
    logic [DATA_W-1:0] imm_q, pc4_q;
    logic [REG_W-1:0]  rs_q, rt_q, rd_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;
    logic              bubble;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .ex_mem_read_i (is_load(ctrl_q)),
        .ex_rt_i       (rt_q),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_use_rs_i   (id_use_rs),
        .id_use_rt_i   (id_use_rt),
        .hazard_o      (hazard)
    );

    assign stall  = hazard & ~reset;
    assign bubble = flush | stall;

    always_comb begin
        ctrl_d = bubble ? '0 : id_ctrl;
        cnt_d  = cnt_q;
        // saturate instead of wrapping so long runs stay meaningful
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            pc4_q     <= id_pc4;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rd_q      <= id_rd;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_ctrl    = ctrl_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm     = imm_q;
    assign ex_pc4     = pc4_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed vector bench for id_ex_hazard_reg.
// Table of ID inputs with expected stall and EX contents, plus reset/saturation sequences.
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] id_ctrl;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic        stall;
    logic [13:0] ex_ctrl;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] bubble_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg dut (
        .clk        (clk),
        .reset      (reset),
        .id_ctrl    (id_ctrl),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm     (id_imm),
        .id_pc4     (id_pc4),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .flush      (flush),
        .stall      (stall),
        .ex_ctrl    (ex_ctrl),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_imm     (ex_imm),
        .ex_pc4     (ex_pc4),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .bubble_cnt (bubble_cnt)
    );

    typedef struct {
        logic [13:0] ctrl;
        logic        use_rs;
        logic        use_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        fl;
        logic        exp_stall;
        logic [13:0] exp_ctrl;
        logic        chk_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v, input int i);
        id_ctrl    = v.ctrl;
        id_use_rs  = v.use_rs;
        id_use_rt  = v.use_rt;
        id_rs      = v.rs;
        id_rt      = v.rt;
        id_rd      = v.rd;
        flush      = v.fl;
        id_rs_data = 32'hA000_0000 + 32'(i);
        id_rt_data = 32'hB000_0000 + 32'(i);
        id_imm     = 32'hC000_0000 + 32'(i);
        id_pc4     = 32'h0040_0000 + 32'(4 * i);
    endtask

    initial begin
        // ctrl, use_rs, use_rt, rs, rt, rd, flush, stall, ex_ctrl, chk, cnt
        vecs[0]  = '{14'h2110, 1, 1, 1,  2,  3, 0, 0, 14'h2110, 1, 0};
        vecs[1]  = '{14'h0631, 1, 0, 1,  5,  0, 0, 0, 14'h0631, 1, 0};
        vecs[2]  = '{14'h2110, 1, 1, 5,  6,  7, 0, 1, 14'h0000, 0, 1};
        vecs[3]  = '{14'h2110, 1, 1, 5,  6,  7, 0, 0, 14'h2110, 1, 1};
        vecs[4]  = '{14'h0631, 1, 0, 1,  0,  0, 0, 0, 14'h0631, 1, 1};
        vecs[5]  = '{14'h2110, 1, 1, 0,  0,  8, 0, 0, 14'h2110, 1, 1};
        vecs[6]  = '{14'h0030, 1, 0, 1,  9,  0, 1, 0, 14'h0000, 0, 2};
        vecs[7]  = '{14'h0631, 1, 0, 2,  4,  0, 0, 0, 14'h0631, 1, 2};
        vecs[8]  = '{14'h2110, 0, 1, 3,  4, 10, 1, 1, 14'h0000, 0, 3};
        vecs[9]  = '{14'h2110, 0, 1, 3,  4, 10, 0, 0, 14'h2110, 1, 3};
        vecs[10] = '{14'h0631, 1, 0, 1, 11,  0, 0, 0, 14'h0631, 1, 3};
        vecs[11] = '{14'h2110, 0, 0, 11, 11, 12, 0, 0, 14'h2110, 1, 3};

        // reset with nonzero inputs, including a flush request
        reset = 1'b1;
        drive(vecs[1], 7);
        flush = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_ctrl", 32'(ex_ctrl), 0);
        chk("rst_data", ex_rs_data | ex_rt_data | ex_imm | ex_pc4, 0);
        chk("rst_idx", 32'({ex_rs, ex_rt, ex_rd}), 0);
        chk("rst_cnt", 32'(bubble_cnt), 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i], i);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].exp_ctrl));
            chk($sformatf("v%0d_cnt", i), 32'(bubble_cnt), 32'(vecs[i].exp_cnt));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
                chk($sformatf("v%0d_rt", i), 32'(ex_rt), 32'(vecs[i].rt));
                chk($sformatf("v%0d_rsd", i), ex_rs_data, 32'hA000_0000 + 32'(i));
                chk($sformatf("v%0d_pc4", i), ex_pc4, 32'h0040_0000 + 32'(4 * i));
            end
        end

        // reset arriving while a load-use stall is pending
        drive(vecs[1], 20);
        id_rt = 5'd12;
        @(posedge clk);
        #1;
        drive(vecs[2], 21);
        id_rs = 5'd12;
        @(negedge clk);
        chk("mid_stall_pre", 32'(stall), 1);
        reset = 1'b1;
        #1;
        chk("mid_stall_rst", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("mid_rst_ctrl", 32'(ex_ctrl), 0);
        chk("mid_rst_cnt", 32'(bubble_cnt), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("post_rst_ctrl", 32'(ex_ctrl), 32'h2110);
        chk("post_rst_rd", 32'(ex_rd), 7);

        // saturation: 65535 flushes reach the ceiling, then it holds
        drive(vecs[0], 30);
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_fffe", 32'(bubble_cnt), 32'hFFFE);
        @(posedge clk);
        #1;
        chk("cnt_ffff", 32'(bubble_cnt), 32'hFFFF);
        drive(vecs[2], 31);
        id_rt = 5'd2;
        id_use_rt = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("sat_hold", 32'(bubble_cnt), 32'hFFFF);
        chk("sat_ctrl", 32'(ex_ctrl), 0);
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_after", 32'(bubble_cnt), 32'hFFFF);
        chk("sat_load", 32'(ex_ctrl), 32'h2110);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
